// File: rtl/stream_arbiter_rr_pkg.sv
// Shared constants and types for the round-robin stream arbiter.
package stream_arbiter_rr_pkg;

   localparam int unsigned DefNumReq  = 4;
   localparam int unsigned DefW       = 64;
   localparam int unsigned DefLenBits = 8;

   typedef enum logic {
      StIdle,
      StBurst
   } state_e;

endpackage

// File: rtl/stream_arbiter_rr_if.sv
// Request, data and sink handshake bundle between the requesters, the arbiter and the shared sink.
interface stream_arbiter_rr_if
   import stream_arbiter_rr_pkg::*;
#(
   parameter int unsigned NUM_REQ  = DefNumReq,
   parameter int unsigned W        = DefW,
   parameter int unsigned LEN_BITS = DefLenBits
);

   logic [NUM_REQ-1:0]          req_isReady;
   logic [NUM_REQ*LEN_BITS-1:0] req_len;
   logic [NUM_REQ-1:0]          req_canReceive;
   logic [NUM_REQ*W-1:0]        in;
   logic [NUM_REQ-1:0]          in_isReady;
   logic [NUM_REQ-1:0]          in_canReceive;
   logic [W-1:0]                out;
   logic                        out_isReady;
   logic                        out_canReceive;
   logic                        out_isLast;
   logic [$clog2(NUM_REQ)-1:0]  grant;
   logic                        busy;

   // Arbiter side.
   modport master (
      input  req_isReady,
      input  req_len,
      input  in,
      input  in_isReady,
      input  out_canReceive,
      output req_canReceive,
      output in_canReceive,
      output out,
      output out_isReady,
      output out_isLast,
      output grant,
      output busy
   );

   // Requester / sink side.
   modport slave (
      output req_isReady,
      output req_len,
      output in,
      output in_isReady,
      output out_canReceive,
      input  req_canReceive,
      input  in_canReceive,
      input  out,
      input  out_isReady,
      input  out_isLast,
      input  grant,
      input  busy
   );

endinterface

// File: rtl/stream_arbiter_rr_rr_pick.sv
// Combinational cyclic priority picker: first asserted request at or after ptr_i, wrapping.
module stream_arbiter_rr_rr_pick #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [NUM_REQ-1:0]         onehot_o,
   output logic [$clog2(NUM_REQ)-1:0] idx_o,
   output logic                       any_o
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);

   int unsigned cand;
   logic        found;

   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      found    = 1'b0;
      cand     = 0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         cand = (32'(ptr_i) + off) % NUM_REQ;
         if (!found && req_i[cand]) begin
            found          = 1'b1;
            idx_o          = IdxW'(cand);
            onehot_o[cand] = 1'b1;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/stream_arbiter_rr.sv
// Round-robin arbiter locking one shared stream sink to a requester for a counted burst of beats.
module stream_arbiter_rr
   import stream_arbiter_rr_pkg::*;
#(
   parameter int unsigned NUM_REQ  = DefNumReq,
   parameter int unsigned W        = DefW,
   parameter int unsigned LEN_BITS = DefLenBits
) (
   input logic                 clk,
   input logic                 rst,
   stream_arbiter_rr_if.master bus
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);

   state_e              state_q, state_d;
   logic [LEN_BITS-1:0] cnt_q, cnt_d;
   logic [IdxW-1:0]     grant_q, grant_d;
   logic [IdxW-1:0]     ptr_q, ptr_d;

   logic [NUM_REQ-1:0]  win_onehot;
   logic [IdxW-1:0]     win_idx;
   logic                win_any;
   logic [LEN_BITS-1:0] win_len;

   logic [NUM_REQ-1:0]  req_accept;
   logic [NUM_REQ-1:0]  in_accept;
   logic                out_valid;
   logic                beat;

   stream_arbiter_rr_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_i    (bus.req_isReady),
      .ptr_i    (ptr_q),
      .onehot_o (win_onehot),
      .idx_o    (win_idx),
      .any_o    (win_any)
   );

   assign win_len = bus.req_len[win_idx*LEN_BITS +: LEN_BITS];
   assign beat    = out_valid & bus.out_canReceive;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      req_accept = '0;
      in_accept  = '0;
      out_valid  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (win_any) begin
               req_accept = win_onehot;
               grant_d    = win_idx;
               ptr_d      = (win_idx == IdxW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
               // A zero-length request is consumed without entering a burst.
               if (win_len != '0) begin
                  cnt_d   = win_len;
                  state_d = StBurst;
               end
            end
         end
         StBurst: begin
            out_valid          = bus.in_isReady[grant_q];
            in_accept[grant_q] = bus.out_canReceive;
            if (out_valid && bus.out_canReceive) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == LEN_BITS'(1)) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.req_canReceive = req_accept;
   assign bus.in_canReceive  = in_accept;
   assign bus.out            = bus.in[grant_q*W +: W];
   assign bus.out_isReady    = out_valid;
   assign bus.out_isLast     = (state_q == StBurst) && (cnt_q == LEN_BITS'(1));
   assign bus.grant          = grant_q;
   assign bus.busy           = (state_q == StBurst);

endmodule
